// File: rtl/serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : serial_adder
//  Purpose  : Bit-serial adder, one full-adder cell reused LSB-first across
//             WIDTH cycles; registered sum/cout and a one-cycle done pulse.
//  Revision : 1.0 - initial release
// ============================================================================
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);

  localparam int c_CNT_W = $clog2(WIDTH);
  localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [WIDTH-2:0]   r_res;
  logic               r_carry;
  logic [c_CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0]   r_sum;
  logic               r_cout;

  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_cat;

  assign w_s    = r_a[0] ^ r_b[0] ^ r_carry;
  assign w_c    = (r_a[0] & r_b[0]) | (r_carry & (r_a[0] ^ r_b[0]));
  assign w_last = (r_cnt == c_LAST);
  // Only the upper WIDTH-1 result bits are stored; the bit that would be
  // shifted out is never needed, and the final sum includes this cycle's bit.
  assign w_cat  = {w_s, r_res};

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:  if (start) w_state_nxt = S_RUN;
      S_RUN:   if (w_last) w_state_nxt = S_DONE;
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_a     <= '0;
      r_b     <= '0;
      r_res   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_a     <= a;
            r_b     <= b;
            r_carry <= cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_a     <= r_a >> 1;
          r_b     <= r_b >> 1;
          r_res   <= w_cat[WIDTH-1:1];
          r_carry <= w_c;
          if (w_last) begin
            r_cnt  <= '0;
            r_sum  <= w_cat;
            r_cout <= w_c;
          end else begin
            r_cnt <= r_cnt + c_CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  assign busy = (r_state == S_RUN);
  assign done = (r_state == S_DONE);
  assign sum  = r_sum;
  assign cout = r_cout;

endmodule
`default_nettype wire

// File: tb/tb_serial_adder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_serial_adder
//  Purpose  : Scoreboard bench for serial_adder at WIDTH=8 and WIDTH=2.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_serial_adder;

  localparam int W  = 8;
  localparam int W2 = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic         start, cin, busy, done, cout;
  logic [W-1:0] a, b, sum;

  logic          start2, cin2, busy2, done2, cout2;
  logic [W2-1:0] a2, b2, sum2;

  serial_adder #(.WIDTH(W)) u_dut (
    .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .cin(cin),
    .busy(busy), .done(done), .sum(sum), .cout(cout)
  );

  serial_adder #(.WIDTH(W2)) u_dut2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2),
    .busy(busy2), .done(done2), .sum(sum2), .cout(cout2)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic [W:0]  exp_q[$];
  logic [W2:0] exp2_q[$];
  int          done_cyc[$];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_tests++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Monitor for the WIDTH=8 instance
  int         busy_cnt = 0;
  logic [W:0] prev8    = '0;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt = 0;
      prev8    = '0;
    end else begin
      if (busy) busy_cnt++;
      if (done) begin
        check("busy_len8", busy_cnt, W);
        busy_cnt = 0;
        done_cyc.push_back(cyc);
        if (exp_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done8: got done with sum 0x%0h, expected no done", {cout, sum});
        end else begin
          check("result8", {cout, sum}, exp_q.pop_front());
        end
      end else begin
        check("hold8", {cout, sum}, prev8);
      end
      prev8 = {cout, sum};
    end
  end

  // Monitor for the WIDTH=2 instance
  int          busy_cnt2 = 0;
  logic [W2:0] prev2     = '0;
  always @(negedge clk) begin
    if (rst) begin
      busy_cnt2 = 0;
      prev2     = '0;
    end else begin
      if (busy2) busy_cnt2++;
      if (done2) begin
        check("busy_len2", busy_cnt2, W2);
        busy_cnt2 = 0;
        if (exp2_q.size() == 0) begin
          n_tests++;
          n_fail++;
          $display("FAIL unexpected_done2: got done with sum 0x%0h, expected no done", {cout2, sum2});
        end else begin
          check("result2", {cout2, sum2}, exp2_q.pop_front());
        end
      end else begin
        check("hold2", {cout2, sum2}, prev2);
      end
      prev2 = {cout2, sum2};
    end
  end

  // One operation on the WIDTH=8 instance; iso scrambles operands and pokes
  // start while the operation is in flight.
  task automatic op8(input logic [W-1:0] ia, input logic [W-1:0] ib, input logic ic, input bit iso);
    @(negedge clk);
    a = ia; b = ib; cin = ic; start = 1'b1;
    exp_q.push_back((W+1)'(ia) + (W+1)'(ib) + (W+1)'(ic));
    @(negedge clk);
    start = 1'b0;
    if (iso) begin
      a = '1; b = '1; cin = 1'($urandom_range(0, 1));
    end
    for (int i = 0; i < W + 1; i++) begin
      @(negedge clk);
      start = iso && (i < W) && ((i == 3) || ($urandom_range(0, 1) == 1));
      if (iso) a = W'($urandom);
    end
    start = 1'b0;
  endtask

  task automatic op2(input logic [W2-1:0] ia, input logic [W2-1:0] ib, input logic ic);
    @(negedge clk);
    a2 = ia; b2 = ib; cin2 = ic; start2 = 1'b1;
    exp2_q.push_back((W2+1)'(ia) + (W2+1)'(ib) + (W2+1)'(ic));
    @(negedge clk);
    start2 = 1'b0;
    a2 = W2'($urandom); b2 = W2'($urandom); cin2 = 1'($urandom_range(0, 1));
    repeat (W2 + 1) @(negedge clk);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    start = 1'b0; a = '0; b = '0; cin = 1'b0;
    start2 = 1'b0; a2 = '0; b2 = '0; cin2 = 1'b0;
    #1;
    check("reset_out8", {busy, done, cout, sum}, '0);
    check("reset_out2", {busy2, done2, cout2, sum2}, '0);
    repeat (3) @(posedge clk);
    #2 rst = 1'b0;

    // Directed cases
    op8(8'h5A, 8'h33, 1'b0, 1'b0);
    op8(8'hFF, 8'h01, 1'b0, 1'b0);
    op8(8'hFF, 8'hFF, 1'b1, 1'b0);
    op8(8'h12, 8'h34, 1'b0, 1'b1);

    // Back-to-back with start held high
    done_cyc.delete();
    @(negedge clk);
    a = 8'h01; b = 8'h01; cin = 1'b0; start = 1'b1;
    exp_q.push_back(9'h002);
    @(negedge clk);
    a = 8'h80; b = 8'h80;
    exp_q.push_back(9'h100);
    repeat (W + 2) @(negedge clk);
    start = 1'b0;
    repeat (W + 2) @(negedge clk);
    check("b2b_done_count", done_cyc.size(), 2);
    if (done_cyc.size() == 2)
      check("b2b_spacing", done_cyc[1] - done_cyc[0], W + 2);

    // Reset abort between E4 and E5
    @(negedge clk);
    a = 8'hAA; b = 8'h55; cin = 1'b0; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("busy_before_abort", busy, 1'b1);
    #1 rst = 1'b1;
    #1 check("abort_outputs", {busy, done, cout, sum}, '0);
    @(posedge clk);
    #2 rst = 1'b0;
    repeat (W + 3) @(negedge clk);
    op8(8'h0F, 8'h01, 1'b0, 1'b0);

    // Randomized operations
    for (int i = 0; i < 20; i++)
      op8(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)), bit'($urandom_range(0, 1)));

    // WIDTH=2 sweep
    op2(2'd3, 2'd3, 1'b1);
    for (int i = 0; i < 10; i++)
      op2(W2'($urandom), W2'($urandom), 1'($urandom_range(0, 1)));

    repeat (5) @(negedge clk);
    check("drain8", exp_q.size(), 0);
    check("drain2", exp2_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
